// File: rtl/lod_pkg.sv
// Shared types and helpers for the leading/trailing-one scanner.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t - scanner control state (IDLE, EMIT)
//   idx_w   - index width needed to address a WIDTH-bit word
package lod_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/lod_prio.sv
// Combinational priority encoder: position of the highest (MSB_FIRST=1) or lowest set bit.
// Latency: zero cycles, purely combinational.
// Backpressure: none; no handshake.
//
// Ports:
//   vec - word to encode
//   idx - position of the winning set bit, 0 when no bit is set
//   any - high when at least one bit of vec is set
module lod_prio
  import lod_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int IDX_W     = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Later loop iterations overwrite earlier ones, so the iteration order
  // decides which set bit wins: ascending scan leaves the highest, descending
  // scan leaves the lowest.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (vec[i]) idx = IDX_W'(i);
      end else begin
        if (vec[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/lod_scan.sv
// Accepts a word and emits one beat per set bit (MSB- or LSB-first), or a single zero-marker beat.
// Latency: first beat one cycle after acceptance; a word of N set bits takes max(N,1)+1 cycles minimum.
// Backpressure: in_ready low for the whole word; beats hold stable while out_ready is low.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - word handshake, in_data carries the word
//   out_valid/out_ready - beat handshake
//   out_idx             - bit position of the current set bit
//   out_last            - final beat of the word
//   out_zero            - single beat emitted for an all-zero word
module lod_scan
  import lod_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int IDX_W     = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] residue_q;
  logic [IDX_W-1:0] prio_idx;
  logic             prio_any;
  logic             single;
  logic             in_hs;
  logic             out_hs;

  lod_prio #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_prio (
    .vec(residue_q),
    .idx(prio_idx),
    .any(prio_any)
  );

  // At most one bit set: clearing the lowest set bit leaves nothing.
  assign single = ((residue_q & (residue_q - WIDTH'(1))) == '0);

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EMIT;
      EMIT:    if (out_ready && single) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once
  // and a stalled beat cannot change.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        out_idx   = prio_idx;
        out_last  = single;
        out_zero  = !prio_any;
      end
      default: ;
    endcase
  end

  // Residue: loaded on acceptance, one bit retired per beat. For an all-zero
  // word the retired bit is already clear, which is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue_q <= '0;
    end else if (in_hs) begin
      residue_q <= in_data;
    end else if (out_hs) begin
      residue_q <= residue_q & ~(WIDTH'(1) << out_idx);
    end
  end

endmodule

// File: tb/tb_lod_scan.sv
// Bench for lod_scan: three instances (8-bit MSB-first, 8-bit LSB-first, 16-bit MSB-first),
// one selected at a time, checked against a set-bit-list reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_lod_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = 16'h0;

  int errors = 0;
  int checks = 0;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_zero;
  logic [2:0] a_out_idx;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_zero;
  logic [2:0] b_out_idx;
  logic       c_in_ready, c_out_valid, c_out_last, c_out_zero;
  logic [3:0] c_out_idx;

  always #5 clk = ~clk;

  lod_scan #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && (sel == 2'd0)), .in_ready(a_in_ready), .in_data(in_data[7:0]),
    .out_valid(a_out_valid), .out_ready(out_ready && (sel == 2'd0)),
    .out_idx(a_out_idx), .out_last(a_out_last), .out_zero(a_out_zero)
  );

  lod_scan #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && (sel == 2'd1)), .in_ready(b_in_ready), .in_data(in_data[7:0]),
    .out_valid(b_out_valid), .out_ready(out_ready && (sel == 2'd1)),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_zero(b_out_zero)
  );

  lod_scan #(.WIDTH(16), .MSB_FIRST(1'b1)) u_m16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && (sel == 2'd2)), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready && (sel == 2'd2)),
    .out_idx(c_out_idx), .out_last(c_out_last), .out_zero(c_out_zero)
  );

  // Outputs of the currently selected instance
  logic       obs_rdy, obs_vld, obs_last, obs_zero;
  logic [3:0] obs_idx;
  assign obs_rdy  = (sel == 2'd0) ? a_in_ready  : (sel == 2'd1) ? b_in_ready  : c_in_ready;
  assign obs_vld  = (sel == 2'd0) ? a_out_valid : (sel == 2'd1) ? b_out_valid : c_out_valid;
  assign obs_last = (sel == 2'd0) ? a_out_last  : (sel == 2'd1) ? b_out_last  : c_out_last;
  assign obs_zero = (sel == 2'd0) ? a_out_zero  : (sel == 2'd1) ? b_out_zero  : c_out_zero;
  assign obs_idx  = (sel == 2'd0) ? {1'b0, a_out_idx} :
                    (sel == 2'd1) ? {1'b0, b_out_idx} : c_out_idx;

  // Sends one word to the selected instance and checks every presented beat
  // against the list of set-bit positions in emission order.
  task automatic run_word(input logic [15:0] w, input int first_stall, input int stall_pct);
    int          q_idx[$];
    bit          q_last[$];
    bit          q_zero[$];
    int          width;
    bit          msb;
    int          cyc;
    logic [15:0] wm;
    width = (sel == 2'd2) ? 16 : 8;
    msb   = (sel != 2'd1);
    wm    = (width == 8) ? (w & 16'h00FF) : w;
    if (wm == 16'h0) begin
      q_idx.push_back(0); q_last.push_back(1'b1); q_zero.push_back(1'b1);
    end else begin
      for (int k = 0; k < width; k++) begin
        int b;
        b = msb ? (width - 1 - k) : k;
        if (wm[b]) begin
          q_idx.push_back(b); q_last.push_back(1'b0); q_zero.push_back(1'b0);
        end
      end
      q_last[q_last.size()-1] = 1'b1;
    end

    checks++;
    if (obs_rdy !== 1'b1 || obs_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_accept sel=%0d: in_ready=%b out_valid=%b, want 1 0", sel, obs_rdy, obs_vld);
    end
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); @(negedge clk);

    cyc = 0;
    while (q_idx.size() > 0 && cyc < 200) begin
      checks++;
      if (obs_vld !== 1'b1 || obs_rdy !== 1'b0 || obs_idx !== 4'(q_idx[0]) ||
          obs_last !== q_last[0] || obs_zero !== q_zero[0]) begin
        errors++;
        $display("FAIL beat sel=%0d word=%h: vld=%b rdy=%b idx=%0d last=%b zero=%b, want 1 0 %0d %b %b",
                 sel, w, obs_vld, obs_rdy, obs_idx, obs_last, obs_zero, q_idx[0], q_last[0], q_zero[0]);
      end
      out_ready = (cyc >= first_stall) && ($urandom_range(99) >= 32'(stall_pct));
      // Input side must be ignored while a word is in flight.
      in_valid  = 1'($urandom_range(1));
      in_data   = 16'($urandom);
      @(posedge clk); @(negedge clk);
      if (out_ready) begin
        void'(q_idx.pop_front()); void'(q_last.pop_front()); void'(q_zero.pop_front());
      end
      out_ready = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    if (q_idx.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout sel=%0d word=%h: %0d beats outstanding, want 0", sel, w, q_idx.size());
    end
    checks++;
    if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL return_idle sel=%0d word=%h: vld=%b rdy=%b, want 0 1", sel, w, obs_vld, obs_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0; sel = 2'd0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({a_in_ready, a_out_valid, a_out_idx, a_out_last, a_out_zero} !== 7'b1_0_000_0_0) begin
      errors++;
      $display("FAIL reset_m8: rdy=%b vld=%b idx=%0d last=%b zero=%b, want 1 0 0 0 0",
               a_in_ready, a_out_valid, a_out_idx, a_out_last, a_out_zero);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_out_idx, b_out_last, b_out_zero} !== 7'b1_0_000_0_0) begin
      errors++;
      $display("FAIL reset_l8: rdy=%b vld=%b idx=%0d last=%b zero=%b, want 1 0 0 0 0",
               b_in_ready, b_out_valid, b_out_idx, b_out_last, b_out_zero);
    end
    checks++;
    if ({c_in_ready, c_out_valid, c_out_idx, c_out_last, c_out_zero} !== 8'b1_0_0000_0_0) begin
      errors++;
      $display("FAIL reset_m16: rdy=%b vld=%b idx=%0d last=%b zero=%b, want 1 0 0 0 0",
               c_in_ready, c_out_valid, c_out_idx, c_out_last, c_out_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    sel = 2'd0; run_word(16'h00A1, 0, 0);   // beats 7, 5, 0
    sel = 2'd1; run_word(16'h00FF, 0, 0);   // beats 0..7
    sel = 2'd2; run_word(16'h0000, 0, 0);   // single zero beat
    sel = 2'd2; run_word(16'h8001, 3, 0);   // idx 15 held 4 cycles, then 0
  endtask

  task automatic test_reset_mid();
    sel = 2'd0;
    in_valid = 1'b1; in_data = 16'h00C0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs_vld !== 1'b1 || obs_idx !== 4'd7 || obs_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_first: vld=%b idx=%0d last=%b, want 1 7 0", obs_vld, obs_idx, obs_last);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (obs_vld !== 1'b1 || obs_idx !== 4'd6 || obs_last !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_second: vld=%b idx=%0d last=%b, want 1 6 1", obs_vld, obs_idx, obs_last);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vld !== 1'b0 || obs_rdy !== 1'b1 || obs_idx !== 4'd0 || obs_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: vld=%b rdy=%b idx=%0d last=%b, want 0 1 0 0", obs_vld, obs_rdy, obs_idx, obs_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) begin
        errors++;
        $display("FAIL rst_no_beat cycle %0d: vld=%b rdy=%b, want 0 1", i, obs_vld, obs_rdy);
      end
    end
    out_ready = 1'b0;
    run_word(16'h0005, 0, 30);
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    in_valid = 1'b1; in_data = 16'h0001;
    @(posedge clk); @(negedge clk);
    in_data = 16'h0080;
    checks++;
    if (obs_vld !== 1'b1 || obs_rdy !== 1'b0 || obs_idx !== 4'd0 || obs_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: vld=%b rdy=%b idx=%0d last=%b, want 1 0 0 1", obs_vld, obs_rdy, obs_idx, obs_last);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: vld=%b rdy=%b, want 0 1", obs_vld, obs_rdy);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs_vld !== 1'b1 || obs_rdy !== 1'b0 || obs_idx !== 4'd7 || obs_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: vld=%b rdy=%b idx=%0d last=%b, want 1 0 7 1", obs_vld, obs_rdy, obs_idx, obs_last);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: vld=%b rdy=%b, want 0 1", obs_vld, obs_rdy);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int n = 0; n < 25; n++) begin
        w = 16'($urandom);
        case ($urandom_range(3))
          0:       w = 16'h0;
          1:       w = w & 16'($urandom) & 16'($urandom);
          default: ;
        endcase
        run_word(w, 0, 30);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lod_scan.md
LOD_SCAN -- requirements
Module: lod_scan

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the input word width, with legal values 2..256.
REQ-002 Parameter MSB_FIRST, default 1, SHALL select emission order: 1 descending from the MSB, 0 ascending from the LSB.
REQ-003 Derived constant IDX_W SHALL equal $clog2(WIDTH) and SHALL NOT be user-overridable.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds a word.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-008 in_data  input  WIDTH  SHALL carry the word to scan.
REQ-009 out_valid  output  1  SHALL indicate that an index beat is presented.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the beat.
REQ-011 out_idx  output  IDX_W  SHALL carry the bit position of the current set bit.
REQ-012 out_last  output  1  SHALL mark the final beat of a word.
REQ-013 out_zero  output  1  SHALL mark the single beat emitted for an all-zero word.

Function
REQ-014 The block SHALL have two states:
- IDLE: in_ready=1, out_valid=0.
- EMIT: in_ready=0, out_valid=1.
REQ-015 A word SHALL be accepted only on in_valid && in_ready; the accepting edge SHALL load a residue register with in_data and move the block to EMIT.
REQ-016 First-beat latency SHALL be one cycle: out_valid is high in the cycle after acceptance.
REQ-017 In EMIT, out_idx SHALL be the highest set residue bit when MSB_FIRST=1, or the lowest set residue bit when MSB_FIRST=0, decoded combinationally from the registered residue.
REQ-018 out_last SHALL be 1 exactly when the residue holds at most one set bit.
REQ-019 On out_valid && out_ready, the bit at out_idx SHALL be cleared in the residue; if out_last=1, the block SHALL return to IDLE.
REQ-020 For an all-zero word, the block SHALL emit exactly one beat with out_zero=1, out_last=1 and out_idx=0; out_zero SHALL be 0 on every other beat.
REQ-021 While out_valid=1 and out_ready=0, out_idx, out_last and out_zero SHALL hold stable.
REQ-022 in_ready SHALL NOT rise in the same cycle as the last handshake.
- The next word SHALL be accepted no earlier than the cycle after return to IDLE.
- A word of N set bits therefore occupies max(N,1)+1 cycles minimum.
REQ-023 in_data SHALL be ignored while in_ready=0.
REQ-024 out_ready SHALL be ignored while out_valid=0.
REQ-025 The residue register SHALL be WIDTH bits wide; out_idx SHALL never exceed WIDTH-1.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- state to IDLE;
- residue to 0;
- out_valid, out_last, out_zero and out_idx to 0;
- in_ready to 1.
REQ-027 Reset mid-word SHALL discard the remaining beats, with no beat emitted after release until a new word is accepted.
REQ-028 Deassertion SHALL be synchronised to clk by the integrating design; the block SHALL accept a word on the first clk edge after rst_n=1.

Structure
REQ-029 Shared package lod_pkg SHALL hold:
- the state typedef (IDLE, EMIT);
- a function returning the IDX_W value for a given WIDTH.
REQ-030 Sub-module lod_prio (parameters WIDTH and MSB_FIRST; input vector; outputs index and any-set) SHALL implement the combinational leading/trailing-one encode.
- It SHALL be a loop-based priority encoder valid for any WIDTH.
- lod_scan SHALL instantiate it once.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, in_data=8'b1010_0001, out_ready=1 -> beats out_idx 7, 5, 0; out_last only on idx 0; in_ready=1 one cycle later.
REQ-032 WIDTH=8, MSB_FIRST=0, in_data=8'hFF -> beats idx 0..7 in ascending order; out_last on idx 7; 8 beats total.
REQ-033 WIDTH=16, in_data=16'h0000 -> one beat with out_zero=1, out_last=1, out_idx=0; then IDLE.
REQ-034 WIDTH=16, in_data=16'h8001, out_ready held low 3 cycles -> out_idx=15 stable for 4 cycles; then idx 0 with out_last=1.
REQ-035 Reset mid-word: after the first beat of 8'b1100_0000, pulse rst_n low -> out_valid=0 asynchronously; no idx 6 beat after release; next word scans correctly.
REQ-036 in_valid held high with back-to-back words 8'h01, 8'h80 -> in_ready low throughout EMIT; second word accepted the cycle after return to IDLE; beats idx 0 then idx 7.
